// File: rtl/mm_cios_core.sv
// Word-serial Montgomery multiplier (CIOS): streams X, Y in LSW first, computes X*Y*R^-1 mod M
// against a run-time loadable modulus/n' table, and streams the reduced result out.
module mm_cios_core #(
  parameter int unsigned K         = 128,
  parameter int unsigned N         = 32,
  parameter int unsigned MOD_SLOTS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mod_wr_en,
  input  logic [$clog2(MOD_SLOTS)-1:0] mod_wr_slot,
  input  logic [$clog2(N)-1:0]         mod_wr_addr,
  input  logic [K-1:0]                 mod_wr_data,
  input  logic                         ninv_wr_en,
  input  logic [K-1:0]                 ninv_wr_data,
  input  logic [$clog2(MOD_SLOTS)-1:0] mm_type,
  input  logic                         mm_start,
  input  logic [K-1:0]                 mm_x,
  input  logic [K-1:0]                 mm_y,
  input  logic                         mm_x_valid,
  input  logic                         mm_y_valid,
  output logic                         mm_ready,
  output logic [K-1:0]                 mm_result,
  output logic                         mm_valid,
  input  logic                         mm_result_ready,
  output logic                         mm_last,
  output logic                         mm_busy
);

  localparam int unsigned SlotW = $clog2(MOD_SLOTS);
  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned TW    = $clog2(N + 2);
  localparam int unsigned SW    = $clog2(2 * N + 2);
  localparam int unsigned KW    = $clog2(N + 1);

  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);
  localparam logic [SW-1:0]   SPhC    = SW'(N);
  localparam logic [SW-1:0]   SPhM    = SW'(N + 1);
  localparam logic [SW-1:0]   SPhB    = SW'(N + 2);
  localparam logic [SW-1:0]   SLast   = SW'(2 * N + 1);
  localparam logic [KW-1:0]   KSel    = KW'(N);

  typedef enum logic [2:0] {StIdle, StLoad, StCompute, StSub, StOut} state_e;

  state_e            state_q, state_d;
  logic [SlotW-1:0]  type_q, type_d;
  logic [IdxW-1:0]   wcnt_q, wcnt_d;
  logic [IdxW-1:0]   icnt_q, icnt_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [KW-1:0]     kcnt_q, kcnt_d;
  logic [IdxW-1:0]   ocnt_q, ocnt_d;

  // Modulus table and operand/accumulator storage (not on the reset net)
  logic [K-1:0] mod_tab  [MOD_SLOTS][N];
  logic [K-1:0] ninv_tab [MOD_SLOTS];
  logic [K-1:0] x_q [N];
  logic [K-1:0] y_q [N];
  logic [K-1:0] t_q [N+2];
  logic [K-1:0] d_q [N];
  logic [K-1:0] m_q;
  logic [K-1:0] carry_q;
  logic         borrow_q;
  logic         sel_t_q;

  logic             accept;
  logic             wr_block;
  logic             ph_a, ph_c, ph_m, ph_b;
  logic [IdxW-1:0]  j_idx;
  logic [IdxW-1:0]  k_idx;
  logic [K-1:0]     mul_a, mul_b;
  logic [2*K-1:0]   prod;
  logic [K-1:0]     carry_in;
  logic [2*K-1:0]   acc;
  logic [K-1:0]     tn_add;
  logic [K:0]       tn_sum;
  logic             borrow_in;
  logic [K:0]       sub_diff;

  assign accept   = (state_q == StLoad) && mm_x_valid && mm_y_valid;
  assign wr_block = (state_q != StIdle) && (mod_wr_slot == type_q);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      type_q  <= '0;
      wcnt_q  <= '0;
      icnt_q  <= '0;
      scnt_q  <= '0;
      kcnt_q  <= '0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      wcnt_q  <= wcnt_d;
      icnt_q  <= icnt_d;
      scnt_q  <= scnt_d;
      kcnt_q  <= kcnt_d;
      ocnt_q  <= ocnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    wcnt_d  = wcnt_q;
    icnt_d  = icnt_q;
    scnt_d  = scnt_q;
    kcnt_d  = kcnt_q;
    ocnt_d  = ocnt_q;
    unique case (state_q)
      StIdle: begin
        if (mm_start) begin
          state_d = StLoad;
          type_d  = mm_type;
          wcnt_d  = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          if (wcnt_q == IdxLast) begin
            state_d = StCompute;
            icnt_d  = '0;
            scnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + IdxW'(1);
          end
        end
      end
      StCompute: begin
        if (scnt_q == SLast) begin
          scnt_d = '0;
          if (icnt_q == IdxLast) begin
            state_d = StSub;
            kcnt_d  = '0;
          end else begin
            icnt_d = icnt_q + IdxW'(1);
          end
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      StSub: begin
        if (kcnt_q == KSel) begin
          state_d = StOut;
          ocnt_d  = '0;
        end else begin
          kcnt_d = kcnt_q + KW'(1);
        end
      end
      StOut: begin
        if (mm_result_ready) begin
          if (ocnt_q == IdxLast) begin
            state_d = StIdle;
          end else begin
            ocnt_d = ocnt_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: one shared KxK multiplier, one 2K accumulate adder
  // ---------------------------------------------------------------------------
  assign ph_a  = (state_q == StCompute) && (scnt_q < SPhC);
  assign ph_c  = (state_q == StCompute) && (scnt_q == SPhC);
  assign ph_m  = (state_q == StCompute) && (scnt_q == SPhM);
  assign ph_b  = (state_q == StCompute) && (scnt_q >= SPhB);
  assign j_idx = IdxW'(ph_a ? scnt_q : scnt_q - SPhB);
  assign k_idx = IdxW'(kcnt_q);

  always_comb begin
    mul_a = x_q[j_idx];
    mul_b = y_q[icnt_q];
    if (ph_m) begin
      mul_a = t_q[0];
      mul_b = ninv_tab[type_q];
    end else if (ph_b) begin
      mul_a = m_q;
      mul_b = mod_tab[type_q][j_idx];
    end
  end

  assign prod     = {{K{1'b0}}, mul_a} * {{K{1'b0}}, mul_b};
  assign carry_in = ((scnt_q == '0) || (scnt_q == SPhB)) ? '0 : carry_q;
  assign acc      = prod + {{K{1'b0}}, t_q[TW'(j_idx)]} + {{K{1'b0}}, carry_in};
  // Shared top-word adder: carry fold after phase A, and the shift-down tail of phase B
  assign tn_add   = ph_c ? carry_q : acc[2*K-1:K];
  assign tn_sum   = {1'b0, t_q[N]} + {1'b0, tn_add};

  assign borrow_in = (kcnt_q == '0) ? 1'b0 : borrow_q;
  assign sub_diff  = {1'b0, t_q[TW'(k_idx)]} - {1'b0, mod_tab[type_q][k_idx]}
                   - {{K{1'b0}}, borrow_in};

  always_ff @(posedge clk) begin
    if (mod_wr_en && !wr_block) begin
      mod_tab[mod_wr_slot][mod_wr_addr] <= mod_wr_data;
    end
    if (ninv_wr_en && !wr_block) begin
      ninv_tab[mod_wr_slot] <= ninv_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == StIdle) && mm_start) begin
      for (int w = 0; w < N + 2; w++) begin
        t_q[w] <= '0;
      end
    end
    if (accept) begin
      x_q[wcnt_q] <= mm_x;
      y_q[wcnt_q] <= mm_y;
    end
    if (ph_a) begin
      t_q[TW'(j_idx)] <= acc[K-1:0];
      carry_q         <= acc[2*K-1:K];
    end
    if (ph_c) begin
      t_q[N]   <= tn_sum[K-1:0];
      t_q[N+1] <= {{(K-1){1'b0}}, tn_sum[K]};
    end
    if (ph_m) begin
      m_q <= prod[K-1:0];
    end
    if (ph_b) begin
      carry_q <= acc[2*K-1:K];
      // Word 0 of T + m*M is zero by construction of m and is dropped
      if (j_idx != '0) begin
        t_q[TW'(j_idx - IdxW'(1))] <= acc[K-1:0];
      end
      if (j_idx == IdxLast) begin
        t_q[N-1] <= tn_sum[K-1:0];
        t_q[N]   <= t_q[N+1] + {{(K-1){1'b0}}, tn_sum[K]};
        t_q[N+1] <= '0;
      end
    end
    if (state_q == StSub) begin
      if (kcnt_q != KSel) begin
        d_q[k_idx] <= sub_diff[K-1:0];
        borrow_q   <= sub_diff[K];
      end else begin
        // Keep T when T - M underflows once T[N] is included
        sel_t_q <= borrow_q & (t_q[N] == '0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mm_ready  = (state_q == StLoad);
  assign mm_valid  = (state_q == StOut);
  assign mm_last   = mm_valid && (ocnt_q == IdxLast);
  assign mm_busy   = (state_q != StIdle);
  assign mm_result = mm_valid ? (sel_t_q ? t_q[TW'(ocnt_q)] : d_q[ocnt_q]) : '0;

endmodule

// File: tb/tb_mm_cios_core.sv
// Directed bench for mm_cios_core at K=16, N=2: hand-computed Montgomery products on several
// moduli, plus latency, backpressure, input gaps, ignored starts, table write drop and reset.
module tb_mm_cios_core;

  localparam int unsigned K         = 16;
  localparam int unsigned N         = 2;
  localparam int unsigned MOD_SLOTS = 4;
  localparam int          Latency   = N * (2 * N + 2) + N + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mod_wr_en = 1'b0;
  logic [1:0]    mod_wr_slot = '0;
  logic          mod_wr_addr = 1'b0;
  logic [K-1:0]  mod_wr_data = '0;
  logic          ninv_wr_en = 1'b0;
  logic [K-1:0]  ninv_wr_data = '0;
  logic [1:0]    mm_type = '0;
  logic          mm_start = 1'b0;
  logic [K-1:0]  mm_x = '0;
  logic [K-1:0]  mm_y = '0;
  logic          mm_x_valid = 1'b0;
  logic          mm_y_valid = 1'b0;
  logic          mm_ready;
  logic [K-1:0]  mm_result;
  logic          mm_valid;
  logic          mm_result_ready = 1'b1;
  logic          mm_last;
  logic          mm_busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;

  mm_cios_core #(
    .K         (K),
    .N         (N),
    .MOD_SLOTS (MOD_SLOTS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mod_wr_en       (mod_wr_en),
    .mod_wr_slot     (mod_wr_slot),
    .mod_wr_addr     (mod_wr_addr),
    .mod_wr_data     (mod_wr_data),
    .ninv_wr_en      (ninv_wr_en),
    .ninv_wr_data    (ninv_wr_data),
    .mm_type         (mm_type),
    .mm_start        (mm_start),
    .mm_x            (mm_x),
    .mm_y            (mm_y),
    .mm_x_valid      (mm_x_valid),
    .mm_y_valid      (mm_y_valid),
    .mm_ready        (mm_ready),
    .mm_result       (mm_result),
    .mm_valid        (mm_valid),
    .mm_result_ready (mm_result_ready),
    .mm_last         (mm_last),
    .mm_busy         (mm_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 500us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tab(input logic [1:0] slot, input logic [31:0] m, input logic [15:0] ninv);
    mod_wr_slot  = slot;
    mod_wr_addr  = 1'b0;
    mod_wr_data  = m[15:0];
    mod_wr_en    = 1'b1;
    ninv_wr_en   = 1'b1;
    ninv_wr_data = ninv;
    tick();
    mod_wr_addr  = 1'b1;
    mod_wr_data  = m[31:16];
    ninv_wr_en   = 1'b0;
    tick();
    mod_wr_en    = 1'b0;
  endtask

  // Full operation; stall/gap/wr_busy select the extra scenarios
  task automatic run_op(input logic [1:0] slot, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input string tag,
                        input bit stall, input bit gap, input bit wr_busy);
    int c_acc;
    int c_val;
    logic [31:0] res;
    logic [15:0] hold;
    res = '0;
    mm_type  = slot;
    mm_start = 1'b1;
    tick();
    mm_start = 1'b0;
    mm_type  = '0;
    check({tag, " ready_after_start"}, 32'(mm_ready), 32'd1);
    mm_x = x[15:0];
    mm_y = y[15:0];
    mm_x_valid = 1'b1;
    mm_y_valid = 1'b1;
    tick();
    if (gap) begin
      mm_x = x[31:16];
      mm_y_valid = 1'b0;
      repeat (3) tick();
      check({tag, " gap_not_consumed"}, 32'(mm_ready), 32'd1);
    end
    mm_x = x[31:16];
    mm_y = y[31:16];
    mm_x_valid = 1'b1;
    mm_y_valid = 1'b1;
    c_acc = cyc;
    tick();
    mm_x_valid = 1'b0;
    mm_y_valid = 1'b0;
    // Restart attempt while computing must be ignored
    mm_type  = 2'd3;
    mm_start = 1'b1;
    tick();
    mm_start = 1'b0;
    mm_type  = '0;
    if (wr_busy) begin
      write_tab(2'd0, 32'h1234_5679, 16'h7777);
      write_tab(2'd3, 32'hFFFF_FFFF, 16'h0001);
    end
    for (int k = 0; k < 100; k++) begin
      if (mm_valid) break;
      tick();
    end
    c_val = cyc;
    check({tag, " latency"}, 32'(c_val - c_acc), 32'(Latency));
    for (int w = 0; w < N; w++) begin
      if (stall) begin
        hold = mm_result;
        mm_result_ready = 1'b0;
        tick();
        tick();
        check({tag, " stall_valid"}, 32'(mm_valid), 32'd1);
        check({tag, " stall_word"}, 32'(mm_result), 32'(hold));
        mm_result_ready = 1'b1;
      end
      check({tag, " last"}, 32'(mm_last), (w == N - 1) ? 32'd1 : 32'd0);
      res[w*16 +: 16] = mm_result;
      tick();
    end
    check({tag, " busy_low"}, 32'(mm_busy), 32'd0);
    check({tag, " result"}, res, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(mm_ready), 32'd0);
    check("reset valid", 32'(mm_valid), 32'd0);
    check("reset last", 32'(mm_last), 32'd0);
    check("reset busy", 32'(mm_busy), 32'd0);
    check("reset result", 32'(mm_result), 32'd0);
    rst_n = 1'b1;
    tick();

    // M = 2^32-1: R = 1 mod M, so result is X*Y mod M
    write_tab(2'd0, 32'hFFFF_FFFF, 16'h0001);
    // M = 2^32-3: R = 3 mod M, result is X*Y/3 mod M
    write_tab(2'd1, 32'hFFFF_FFFD, 16'hAAAB);
    // M = 3: R = 1 mod 3
    write_tab(2'd2, 32'h0000_0003, 16'h5555);

    run_op(2'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006, "s0 2x3", 1'b0, 1'b0, 1'b0);
    run_op(2'd0, 32'hFFFF_FFFE, 32'h0000_0002, 32'hFFFF_FFFD, "s0 m1x2", 1'b0, 1'b0, 1'b0);
    run_op(2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_0001, "s0 m1xm1", 1'b0, 1'b0, 1'b0);
    run_op(2'd1, 32'h0000_0003, 32'h0000_0001, 32'h0000_0001, "s1 3x1", 1'b0, 1'b0, 1'b0);
    run_op(2'd1, 32'h0000_0006, 32'h0000_0005, 32'h0000_000A, "s1 6x5 stall", 1'b1, 1'b0,
           1'b0);
    run_op(2'd1, 32'hFFFF_FFFC, 32'h0000_0003, 32'hFFFF_FFFC, "s1 m1x3 gap", 1'b0, 1'b1,
           1'b0);
    run_op(2'd2, 32'h0000_0002, 32'h0000_0002, 32'h0000_0001, "s2 2x2", 1'b0, 1'b0, 1'b0);
    run_op(2'd2, 32'h0000_0001, 32'h0000_0002, 32'h0000_0002, "s2 1x2", 1'b0, 1'b0, 1'b0);

    // Busy on slot 0: its write is dropped, slot 3 write lands
    run_op(2'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006, "s0 wr_busy", 1'b0, 1'b0, 1'b1);
    run_op(2'd0, 32'hFFFF_FFFE, 32'h0000_0002, 32'hFFFF_FFFD, "s0 after drop", 1'b0, 1'b0,
           1'b0);
    run_op(2'd3, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006, "s3 written", 1'b0, 1'b0, 1'b0);

    // Reset in the middle of COMPUTE
    mm_type  = 2'd1;
    mm_start = 1'b1;
    tick();
    mm_start   = 1'b0;
    mm_x       = 16'h0006;
    mm_y       = 16'h0005;
    mm_x_valid = 1'b1;
    mm_y_valid = 1'b1;
    tick();
    tick();
    mm_x_valid = 1'b0;
    mm_y_valid = 1'b0;
    repeat (4) tick();
    check("midrst busy_before", 32'(mm_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(mm_busy), 32'd0);
    check("midrst ready", 32'(mm_ready), 32'd0);
    check("midrst valid", 32'(mm_valid), 32'd0);
    check("midrst last", 32'(mm_last), 32'd0);
    check("midrst result", 32'(mm_result), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst idle", 32'(mm_busy), 32'd0);
    run_op(2'd1, 32'h0000_0006, 32'h0000_0005, 32'h0000_000A, "s1 after rst", 1'b0, 1'b0,
           1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
